// File: rtl/clk_div_manager_if.sv
// Ratio-write handshake between the timebase controller and clk_div_manager.
// master drives the write offer; slave (the divider block) returns cfg_ready.
interface clk_div_manager_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV_W  = 16
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready
    );
endinterface

// File: rtl/clk_div_manager.sv
// Multi-channel clock-enable generator with post-reset lock and runtime ratio reload.
// CLKDIV_GLITCHFREE_EN: defer new ratios to the channel's next wrap instead of restarting.
module clk_div_manager #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DIV_INIT    = 2,
    parameter int unsigned LOCK_CYCLES = 64
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    clk_div_manager_if.slave  cfg,
    output logic [NUM_CH-1:0] clk_en_o,
    output logic [NUM_CH-1:0] clk_out_o,
    output logic              locked_o
);
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LOCK_W-1:0] LockLast = LOCK_W'(LOCK_CYCLES - 1);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                         state_q, state_d;
    logic [LOCK_W-1:0]              lock_cnt_q, lock_cnt_d;
    logic                           locked_q, ready_q;
    logic [NUM_CH-1:0]              en_q, en_d, out_q, out_d;
    logic [NUM_CH-1:0][DIV_W-1:0]   cnt_q, cnt_d, div_q, div_d, half_d;
    logic [NUM_CH-1:0]              wr_ch, wrap_ch;
    logic [DIV_W-1:0]               new_div;
`ifdef CLKDIV_GLITCHFREE_EN
    logic [NUM_CH-1:0]              pend_q, pend_d;
    logic [NUM_CH-1:0][DIV_W-1:0]   pend_div_q, pend_div_d;
`endif

    assign cfg.cfg_ready = ready_q;
    assign locked_o      = locked_q;
    assign clk_en_o      = en_q;
    assign clk_out_o     = out_q;

    // A zero ratio behaves as divide-by-one.
    assign new_div = (cfg.cfg_div == '0) ? DIV_W'(1) : cfg.cfg_div;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            StInit: begin
                if (lock_cnt_q == LockLast) begin
                    state_d = StRun;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        wr_ch   = '0;
        wrap_ch = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_ch[i]   = cfg.cfg_valid && ready_q && (cfg.cfg_ch == CH_W'(i));
            wrap_ch[i] = (cnt_q[i] == div_q[i] - DIV_W'(1));
        end
    end

    // Counters only advance once locked_q is high, so every channel leaves 0 together.
    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
`ifdef CLKDIV_GLITCHFREE_EN
        pend_d     = pend_q;
        pend_div_d = pend_div_q;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (locked_q) begin
                cnt_d[i] = wrap_ch[i] ? '0 : cnt_q[i] + DIV_W'(1);
`ifdef CLKDIV_GLITCHFREE_EN
                if (wr_ch[i]) begin
                    pend_d[i]     = 1'b1;
                    pend_div_d[i] = new_div;
                end
                if (wrap_ch[i]) begin
                    if (wr_ch[i]) begin
                        div_d[i] = new_div;
                    end else if (pend_q[i]) begin
                        div_d[i] = pend_div_q[i];
                    end
                    pend_d[i] = 1'b0;
                end
`else
                if (wr_ch[i]) begin
                    div_d[i] = new_div;
                    cnt_d[i] = '0;
                end
`endif
            end
        end
    end

    // Outputs are registered from next-state values so they line up with cnt_q.
    always_comb begin
        en_d   = '0;
        out_d  = '0;
        half_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            half_d[i] = (div_d[i] >> 1) + DIV_W'(div_d[i][0]);
            if (state_q == StRun) begin
                en_d[i]  = (cnt_d[i] == div_d[i] - DIV_W'(1));
                out_d[i] = (cnt_d[i] < half_d[i]);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StInit;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            ready_q    <= 1'b0;
            en_q       <= '0;
            out_q      <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= DIV_W'(DIV_INIT);
            end
`ifdef CLKDIV_GLITCHFREE_EN
            pend_q     <= '0;
            pend_div_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= (state_q == StRun);
            ready_q    <= (state_q == StRun);
            en_q       <= en_d;
            out_q      <= out_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
`ifdef CLKDIV_GLITCHFREE_EN
            pend_q     <= pend_d;
            pend_div_q <= pend_div_d;
`endif
        end
    end
endmodule

// File: doc/clk_div_manager.md
# clk_div_manager

Parametrised multi-channel clock-enable generator for the acquisition timebase. It is the successor to the fixed 200/400 MHz clocking wrapper. It runs entirely in the `sys_clk` domain and produces `NUM_CH` independently programmable divided strobes (`clk_en`) and square waves (`clk_out`). It also provides a post-reset lock sequence and a runtime ratio-reload handshake. ADC samplers, trigger logic and display refresh consume the strobes as clock enables; no derived clocks are routed.

## Interface
- `NUM_CH`, default 4: number of output channels (1..16).
- `DIV_W`, default 16: width of each divide ratio.
- `DIV_INIT`, default 2: ratio loaded into every channel at reset.
- `LOCK_CYCLES`, default 64: `sys_clk` cycles spent in INIT before `locked` (≥1).
- `sys_clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `cfg_valid`, input, 1: a ratio write is offered.
- `cfg_ready`, output, 1: the block can accept a write.
- `cfg_ch`, input, `max(1,$clog2(NUM_CH))`: target channel. Values ≥ `NUM_CH` are accepted and discarded.
- `cfg_div`, input, `DIV_W`: new ratio. A value of 0 is treated as 1.
- `clk_en`, output, `NUM_CH`: one-cycle strobe per divided period.
- `clk_out`, output, `NUM_CH`: divided square wave.
- `locked`, output, 1: high once channels are running.

## Operation
- **Reset values** (all outputs registered): `cfg_ready`=0, `locked`=0, `clk_en`=0, `clk_out`=0. Every channel ratio `d`=`DIV_INIT`, its counter is 0, and its pending flag is clear.
- **State machine:**
  - INIT: `lock_cnt` counts 0..`LOCK_CYCLES`-1. Channels are held at counter 0 with outputs 0.
  - INIT → RUN on the cycle after `lock_cnt`=`LOCK_CYCLES`-1.
  - RUN is terminal until reset.
- **In RUN:** `locked`=1 and `cfg_ready`=1. All channel counters start together at 0, so channels are phase-aligned at lock.
- **Per-channel counter** `cnt` runs 0..`d`-1 and wraps to 0.
  - `clk_en[i]`=1 exactly in the cycle where `cnt`=`d`-1.
  - `clk_out[i]`=1 while `cnt` < ceil(`d`/2).
  - `d`=1: `clk_en` is constantly 1 and `clk_out` is constantly 1.
  - Odd `d`: `clk_out` high time is one cycle longer than its low time.
- **Arithmetic:** `cnt` is `DIV_W` bits. `d` up to 2^`DIV_W`-1 must work without overflow. The comparison against `d`-1 uses the stored ratio after the zero-to-one substitution.
- **Write handshake:** a write completes on a cycle with `cfg_valid`&&`cfg_ready`. The accepted value goes to the channel's pending register and sets its pending flag.
- **Reload timing:** see Configuration.
- **Repeated writes:** a second write to the same channel while the flag is still set overwrites the pending value (last write wins).
- **Parallel writes:** writes to different channels are independent.
- **Reset mid-operation:** asynchronous return to the reset values. Pending writes are lost and INIT restarts from 0.

## Timing
- Let edge 1 be the first rising edge with `rst_n` high. `locked` and `cfg_ready` rise after edge `LOCK_CYCLES`+1.
- Let k=0 be the first cycle with `locked`=1. With constant `d`:
  - `clk_en[i]` is high iff k mod `d` = `d`-1.
  - `clk_out[i]` is high iff k mod `d` < ceil(`d`/2).
- Write acceptance takes one cycle, with no back-pressure in RUN.
- The ratio-update latency is defined in Configuration.

## Configuration
- Macro: `CLKDIV_GLITCHFREE_EN`.
- **Defined:** a pending ratio is applied at the channel's next wrap (the cycle where `cnt`=`d`-1). The following cycle is `cnt`=0 of a period at the new ratio, and the pending flag clears.
  - A write accepted in the wrap cycle itself is applied at that wrap.
  - The current period always completes, and there is no runt pulse on `clk_out`.
- **Undefined:** the accepted ratio replaces `d` on the next edge and the counter is forced to 0. A new period starts immediately and may truncate the current one. The pending flag is unused.

## Test plan
- Reset with `LOCK_CYCLES`=64, `DIV_INIT`=2 → `locked` rises after edge 65. `clk_en` is then high on k=1,3,5,…; `clk_out` is high on even k.
- Write ch1 `d`=5 (macro defined) at k=10 → ch1 finishes its period at k=11. From k=12 `clk_en` is high at k=16,21,… and `clk_out` is high for 3 cycles then low for 2. Other channels are undisturbed.
- Write ch2 `d`=0 → the ratio behaves as 1: `clk_en[2]` and `clk_out[2]` are constantly 1 after the update.
- Write ch0 `d`=7 then `d`=3 within one period (macro defined) → only `d`=3 is applied at the wrap.
- Macro undefined: write ch3 `d`=4 at `cnt`=1 of a `d`=8 period → the counter is 0 on the next cycle and `clk_en` fires 4 cycles later.
- Assert `rst_n`=0 mid-RUN for 3 cycles → all outputs drop to 0 immediately and the INIT count restarts. `cfg_valid` held high during INIT is not accepted.
